// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus owner arbiter: FSM state encoding and a
// constant ceil(log2) helper used to size index and counter fields.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  // Ceiling log2 evaluated at elaboration time; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned w = 0; w < 32; w++) begin
      if ((64'd1 << w) < 64'(value)) result = w + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: scans Req starting at Ptr, wrapping modulo NReq,
// and returns the first set index.
//   Req    - request vector
//   Ptr    - index with highest priority this scan
//   Found  - any request present
//   WinIdx - winning index (0 when Found==0)
module rr_pick #(
  parameter int unsigned NReq = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NReq-1:0] Req,
  input  logic [IdxW-1:0] Ptr,
  output logic            Found,
  output logic [IdxW-1:0] WinIdx
);

  // First hit in rotated order wins; later hits are masked by the flag.
  always_comb begin
    logic hit;
    hit    = 1'b0;
    WinIdx = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      if (!hit && Req[IdxW'((32'(Ptr) + i) % NReq)]) begin
        hit    = 1'b1;
        WinIdx = IdxW'((32'(Ptr) + i) % NReq);
      end
    end
    Found = hit;
  end

endmodule

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a shared tri-state data bus. Grants one
// requester at a time, caps each ownership at MaxHold cycles and leaves the
// bus undriven for TurnCyc cycles between owners.
//   Clk      - rising-edge clock
//   Rst      - synchronous active-low reset
//   Req      - per-requester level-held bus request
//   Grant    - registered one-hot ownership, zero when the bus is free
//   OwnerIdx - registered binary index of the owner, meaningful while Busy
//   Busy     - registered, high while any Grant bit is set
module bus_owner_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int unsigned NReq    = 4,
  parameter  int unsigned MaxHold = 8,
  parameter  int unsigned TurnCyc = 1,
  localparam int unsigned IdxW    = clog2(NReq)
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [NReq-1:0] Req,
  output logic [NReq-1:0] Grant,
  output logic [IdxW-1:0] OwnerIdx,
  output logic            Busy
);

  localparam int unsigned HoldW = clog2(MaxHold + 1);
  localparam int unsigned TurnW = clog2(TurnCyc + 1);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [TurnW-1:0]  turn_q, turn_d;
  logic [NReq-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic              busy_q, busy_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;

  // Single picker serves both the IDLE and the final TURN cycle.
  rr_pick #(
    .NReq (NReq),
    .IdxW (IdxW)
  ) u_rr_pick (
    .Req    (Req),
    .Ptr    (ptr_q),
    .Found  (pick_found),
    .WinIdx (pick_idx)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    grant_d = grant_q;
    owner_d = owner_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = NReq'(1) << pick_idx;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          hold_d  = HoldW'(1);
          state_d = OWN;
        end
      end

      OWN: begin
        if (Req[owner_q] && (hold_q < HoldW'(MaxHold))) begin
          hold_d = hold_q + HoldW'(1);
        end else begin
          // Release: priority moves just past the departing owner.
          grant_d = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
          ptr_d   = (owner_q == IdxW'(NReq - 1)) ? '0 : owner_q + IdxW'(1);
          turn_d  = TurnW'(TurnCyc);
          state_d = TURN;
        end
      end

      TURN: begin
        if (turn_q == TurnW'(1)) begin
          // Last dead cycle: arbitrate so the new grant abuts the gap.
          turn_d = '0;
          if (pick_found) begin
            grant_d = NReq'(1) << pick_idx;
            owner_d = pick_idx;
            busy_d  = 1'b1;
            hold_d  = HoldW'(1);
            state_d = OWN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_d = turn_q - TurnW'(1);
        end
      end

      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign Grant    = grant_q;
  assign OwnerIdx = owner_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_bus_owner_arbiter.sv
// Self-checking bench for bus_owner_arbiter. Two instances share stimulus:
// A (MaxHold=4, TurnCyc=1) and B (MaxHold=2, TurnCyc=2). A behavioural
// ownership model tracks each instance; directed sequences are also checked
// against hand-derived constants.
module tb_bus_owner_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;

  logic [N-1:0] grant_a, grant_b;
  logic [1:0]   owner_a, owner_b;
  logic         busy_a, busy_b;

  int n_vec = 0;
  int n_err = 0;

  int mh [2] = '{4, 2};
  int tc [2] = '{1, 2};

  // Model state: owner (-1 = bus free), cycles granted so far, dead cycles
  // still to run, and the index searched first.
  int m_owner [2] = '{-1, -1};
  int m_run   [2] = '{0, 0};
  int m_gap   [2] = '{0, 0};
  int m_ptr   [2] = '{0, 0};

  always #5 clk = ~clk;

  bus_owner_arbiter #(
    .NReq    (4),
    .MaxHold (4),
    .TurnCyc (1)
  ) u_dut_a (
    .Clk      (clk),
    .Rst      (rst_n),
    .Req      (req),
    .Grant    (grant_a),
    .OwnerIdx (owner_a),
    .Busy     (busy_a)
  );

  bus_owner_arbiter #(
    .NReq    (4),
    .MaxHold (2),
    .TurnCyc (2)
  ) u_dut_b (
    .Clk      (clk),
    .Rst      (rst_n),
    .Req      (req),
    .Grant    (grant_b),
    .OwnerIdx (owner_b),
    .Busy     (busy_b)
  );

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the ownership model of instance k by one clock edge.
  task automatic model_step(input int k);
    int w;
    if (rst_n == 1'b0) begin
      m_owner[k] = -1;
      m_run[k]   = 0;
      m_gap[k]   = 0;
      m_ptr[k]   = 0;
    end else if (m_owner[k] >= 0) begin
      if (req[2'(m_owner[k])] && m_run[k] < mh[k]) begin
        m_run[k]++;
      end else begin
        m_ptr[k]   = (m_owner[k] + 1) % N;
        m_owner[k] = -1;
        m_run[k]   = 0;
        m_gap[k]   = tc[k];
      end
    end else if (m_gap[k] > 1) begin
      m_gap[k]--;
    end else begin
      m_gap[k] = 0;
      for (int i = 0; i < N; i++) begin
        w = (m_ptr[k] + i) % N;
        if (m_owner[k] < 0 && req[2'(w)]) begin
          m_owner[k] = w;
          m_run[k]   = 1;
        end
      end
    end
  endtask

  task automatic compare(input int k, input logic [N-1:0] g, input logic [1:0] o, input logic b);
    int unsigned eg;
    eg = (m_owner[k] >= 0) ? (32'd1 << m_owner[k]) : 32'd0;
    check_val($sformatf("grant%0d", k), 32'(g), eg);
    check_val($sformatf("busy%0d", k), 32'(b), (m_owner[k] >= 0) ? 32'd1 : 32'd0);
    check_val($sformatf("onehot%0d", k), ($countones(g) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (m_owner[k] >= 0) check_val($sformatf("owner%0d", k), 32'(o), 32'(m_owner[k]));
  endtask

  // Apply inputs, take one edge, then check both instances against the model.
  task automatic cycle(input logic [N-1:0] r, input logic rs);
    req   = r;
    rst_n = rs;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare(0, grant_a, owner_a, busy_a);
    compare(1, grant_b, owner_b, busy_b);
  endtask

  initial begin
    // Reset held with all requests up: nothing granted.
    cycle(4'b1111, 1'b0);
    check_val("rst_grant_a", 32'(grant_a), 32'd0);
    check_val("rst_busy_a", 32'(busy_a), 32'd0);
    check_val("rst_owner_a", 32'(owner_a), 32'd0);
    check_val("rst_owner_b", 32'(owner_b), 32'd0);
    cycle(4'b1111, 1'b0);
    check_val("rst2_grant_b", 32'(grant_b), 32'd0);

    // Continuous 1111: A rotates 4 on / 1 off; B rotates 2 on / 2 off.
    for (int i = 0; i < 21; i++) begin
      cycle(4'b1111, 1'b1);
      check_val($sformatf("rr_a[%0d]", i), 32'(grant_a),
                (i % 5 == 4) ? 32'd0 : (32'd1 << ((i / 5) % 4)));
      check_val($sformatf("rr_b[%0d]", i), 32'(grant_b),
                (i % 4 >= 2) ? 32'd0 : (32'd1 << ((i / 4) % 4)));
    end

    // Single requester 2 held for two cycles, then dropped.
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b1);
    check_val("single_g0", 32'(grant_a), 32'h4);
    check_val("single_busy", 32'(busy_a), 32'd1);
    check_val("single_idx", 32'(owner_a), 32'd2);
    cycle(4'b0100, 1'b1);
    check_val("single_g1", 32'(grant_a), 32'h4);
    cycle(4'b0000, 1'b1);
    check_val("single_rel", 32'(grant_a), 32'h0);
    check_val("single_rel_busy", 32'(busy_a), 32'd0);
    cycle(4'b0000, 1'b1);
    check_val("single_idle", 32'(grant_a), 32'h0);

    // Owner 2 releases with 1010 pending: 3 wins next, then 1.
    cycle(4'b0000, 1'b0);
    cycle(4'b0100, 1'b1);
    check_val("ptr_g2", 32'(grant_a), 32'h4);
    cycle(4'b1010, 1'b1);
    check_val("ptr_gap", 32'(grant_a), 32'h0);
    cycle(4'b1010, 1'b1);
    check_val("ptr_g3", 32'(grant_a), 32'h8);
    cycle(4'b0010, 1'b1);
    check_val("ptr_gap2", 32'(grant_a), 32'h0);
    cycle(4'b0010, 1'b1);
    check_val("ptr_g1", 32'(grant_a), 32'h2);

    // Reset during owner 1's second cycle drops grant and resets priority.
    cycle(4'b0000, 1'b0);
    cycle(4'b0010, 1'b1);
    check_val("mid_g1", 32'(grant_a), 32'h2);
    cycle(4'b0010, 1'b0);
    check_val("mid_rst", 32'(grant_a), 32'h0);
    cycle(4'b0011, 1'b1);
    check_val("mid_after", 32'(grant_a), 32'h1);

    // B with 0011 held: 2 granted, 2 dead, alternating owners 0 and 1.
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(4'b0011, 1'b1);
      check_val($sformatf("turn2_b[%0d]", i), 32'(grant_b),
                (i % 4 >= 2) ? 32'd0 : (32'd1 << ((i / 4) % 2)));
    end

    // Randomized requests with occasional reset, model-checked each cycle.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r = req ^ 4'($urandom & $urandom);
      cycle(r, ($urandom_range(63) != 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
